ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
Sits between PS2_Controller and the note control path. Consumes the raw byte stream (received_data / received_data_en) and turns PS/2 Set-2 multi-byte sequences (E0 extended, F0 break, E1 pause) into single-cycle key press/release events with a clean 8-bit code. Also tracks the most recently pressed, still-held key, so the control path can sustain a note without re-parsing prefixes.

Parameters:
TIMEOUT_CYCLES, 2500000, max CLOCK_50 cycles allowed between bytes of one sequence (50 ms).
CNT_WIDTH, 22, width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
CLOCK_50  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
received_data  in  8  byte from PS2_Controller; valid only when received_data_en=1.
received_data_en  in  1  one-cycle byte strobe.
key_event  out  1  one-cycle pulse: key_code/key_extended/key_released valid.
key_code  out  8  decoded code (prefixes stripped); holds value until next event.
key_extended  out  1  1 if the sequence carried E0 (or was Pause).
key_released  out  1  1 for break, 0 for make.
held_code  out  8  code of the currently held key; 00 when none.
held_extended  out  1  extended flag of held key.
held_valid  out  1  1 while a pressed key has not been released.
seq_error  out  1  one-cycle pulse on a malformed or timed-out sequence.

Behaviour:
- Reset (async, any time incl. mid-sequence): state IDLE, all outputs 0, skip count 0, timeout counter 0.
- All outputs registered. key_event rises the cycle after the strobe of the sequence's final byte (latency 1). Bytes are acted on only when received_data_en=1.
- States: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, skip count = 7.
  - 00, AA, EE, FA, FC, FD, FE, FF are discarded with no event.
  - Any other byte: make event, ext=0.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - 12 or 59 (fake shift): discard, -> IDLE.
  - Other: make event, ext=1, -> IDLE.
- BRK: E0/E1/F0 -> seq_error, -> IDLE; otherwise break event, ext=0, -> IDLE.
- EXT_BRK:
  - E0/E1/F0 -> seq_error, -> IDLE.
  - 12 or 59 -> discard, -> IDLE.
  - Otherwise break event, ext=1, -> IDLE.
- PAUSE: every strobe decrements skip count regardless of value. The strobe taking it from 1 to 0 emits a make event with code=E1, ext=1, -> IDLE. Pause never produces a break.
- Timeout:
  - Counter clears on every strobe and in IDLE; otherwise it increments.
  - When it reaches TIMEOUT_CYCLES-1 in a non-IDLE state, next cycle: state IDLE, seq_error=1.
  - If a strobe coincides with the timeout cycle, the strobe wins (byte processed, no error).
- Held tracking:
  - A make event sets held_code/held_extended and held_valid=1; a newer make replaces the older one.
  - A break matching both held_code and held_extended clears all three to 0. Other breaks leave them unchanged, but still produce key_event.
- key_event and seq_error are never asserted in the same cycle.

Optional Feature:
REPEAT_FILTER_EN.
- Defined: a make event whose code and ext equal held_code/held_extended while held_valid=1 is a typematic repeat and is suppressed. No key_event; key_code unchanged; held state unchanged.
- Undefined: every make emits key_event, including repeats.

Test Plan:
- Bytes 1C; F0 1C -> make (code 1C, ext 0, rel 0), held_valid=1/held_code=1C; then break (1C, 0, 1), held_valid=0. Each key_event is 1 cycle, one cycle after the strobe.
- E0 75; E0 F0 75 -> make (75, ext 1), then break (75, ext 1, rel 1); E0 12 and E0 F0 12 produce no event.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event (E1, ext 1, rel 0) after the 8th byte; no seq_error.
- F0 then idle for TIMEOUT_CYCLES (set to 100 in bench) -> seq_error pulse; next byte 1C decodes as a make. A separate case has a strobe landing on cycle 99 and gives no error.
- Sequence 1C 1C 1C: with REPEAT_FILTER_EN, one key_event; without it, three. Bytes AA and FA in IDLE produce no event in either build.
- Assert reset between E0 and 75 -> all outputs 0; following 75 decodes as make with ext 0.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//
// Turns the raw PS/2 Set-2 byte stream from PS2_Controller into single-cycle
// key press/release events. It strips the E0 (extended), F0 (break) and
// E1 (pause) prefixes and tracks the most recently pressed, still-held key.
//
// Ports:
//   CLOCK_50          system clock
//   reset             asynchronous, active-high reset
//   received_data     byte from PS2_Controller, valid when received_data_en=1
//   received_data_en  one-cycle byte strobe
//   key_event         one-cycle pulse, key_code/key_extended/key_released valid
//   key_code          decoded code with prefixes stripped, held until next event
//   key_extended      sequence carried E0 (or was Pause)
//   key_released      1 for break, 0 for make
//   held_code         code of the currently held key, 00 when none
//   held_extended     extended flag of the held key
//   held_valid        a pressed key has not been released yet
//   seq_error         one-cycle pulse on a malformed or timed-out sequence
//
// Build option:
//   REPEAT_FILTER_EN  when defined, a make that matches the held key
//                     (typematic repeat) is swallowed without an event.

module ps2_scancode_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned CNT_WIDTH      = 22
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released,
    output logic [7:0] held_code,
    output logic       held_extended,
    output logic       held_valid,
    output logic       seq_error
);

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StPause
    } state_e;

    localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e               state;
    logic [2:0]           skip_cnt;
    logic [CNT_WIDTH-1:0] timeout_cnt;

    logic       is_prefix;
    logic       is_fake_shift;
    logic       is_discard;
    logic       is_repeat;
    logic       held_match;

    state_e     state_nxt;
    logic       do_make;
    logic       do_break;
    logic       do_error;
    logic       load_skip;
    logic [7:0] ev_code;
    logic       ev_ext;

    assign is_prefix     = (received_data == 8'hE0) || (received_data == 8'hE1) ||
                           (received_data == 8'hF0);
    // E0 12 / E0 59 are the fake-shift bytes some keyboards wrap around
    // extended keys; they carry no key information.
    assign is_fake_shift = (received_data == 8'h12) || (received_data == 8'h59);
    // Keyboard status / acknowledge bytes that can appear between sequences.
    assign is_discard    = (received_data == 8'h00) || (received_data == 8'hAA) ||
                           (received_data == 8'hEE) || (received_data == 8'hFA) ||
                           (received_data == 8'hFC) || (received_data == 8'hFD) ||
                           (received_data == 8'hFE) || (received_data == 8'hFF);

    assign held_match = (held_code == ev_code) && (held_extended == ev_ext);

`ifdef REPEAT_FILTER_EN
    assign is_repeat = held_valid && held_match;
`else
    assign is_repeat = 1'b0;
`endif

    // Decode of the current byte; all results are registered below.
    always_comb begin
        state_nxt = state;
        do_make   = 1'b0;
        do_break  = 1'b0;
        do_error  = 1'b0;
        load_skip = 1'b0;
        ev_code   = received_data;
        ev_ext    = 1'b0;
        if (received_data_en) begin
            case (state)
                StIdle: begin
                    if (received_data == 8'hE0) begin
                        state_nxt = StExt;
                    end else if (received_data == 8'hF0) begin
                        state_nxt = StBrk;
                    end else if (received_data == 8'hE1) begin
                        state_nxt = StPause;
                        load_skip = 1'b1;
                    end else if (!is_discard) begin
                        do_make = 1'b1;
                    end
                end
                StExt: begin
                    ev_ext = 1'b1;
                    if (received_data == 8'hF0) begin
                        state_nxt = StExtBrk;
                    end else if (received_data == 8'hE0) begin
                        state_nxt = StExt;
                    end else begin
                        state_nxt = StIdle;
                        do_make   = !is_fake_shift;
                    end
                end
                StBrk: begin
                    state_nxt = StIdle;
                    do_error  = is_prefix;
                    do_break  = !is_prefix;
                end
                StExtBrk: begin
                    state_nxt = StIdle;
                    ev_ext    = 1'b1;
                    do_error  = is_prefix;
                    do_break  = !is_prefix && !is_fake_shift;
                end
                StPause: begin
                    // Payload bytes are skipped blindly; the last one
                    // completes the Pause key as an extended make of E1.
                    if (skip_cnt <= 3'd1) begin
                        state_nxt = StIdle;
                        do_make   = 1'b1;
                        ev_code   = 8'hE1;
                        ev_ext    = 1'b1;
                    end
                end
                default: state_nxt = StIdle;
            endcase
        end else if ((state != StIdle) && (timeout_cnt == TimeoutLast)) begin
            state_nxt = StIdle;
            do_error  = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            skip_cnt      <= 3'd0;
            timeout_cnt   <= '0;
            key_event     <= 1'b0;
            key_code      <= 8'h00;
            key_extended  <= 1'b0;
            key_released  <= 1'b0;
            held_code     <= 8'h00;
            held_extended <= 1'b0;
            held_valid    <= 1'b0;
            seq_error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            key_event <= 1'b0;
            seq_error <= do_error;

            if (load_skip) begin
                skip_cnt <= 3'd7;
            end else if (received_data_en && (state == StPause) && (skip_cnt != 3'd0)) begin
                skip_cnt <= skip_cnt - 3'd1;
            end

            if (received_data_en || (state == StIdle) || do_error) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end

            if ((do_make && !is_repeat) || do_break) begin
                key_event    <= 1'b1;
                key_code     <= ev_code;
                key_extended <= ev_ext;
                key_released <= do_break;
            end

            if (do_make && !is_repeat) begin
                held_code     <= ev_code;
                held_extended <= ev_ext;
                held_valid    <= 1'b1;
            end else if (do_break && held_match) begin
                held_code     <= 8'h00;
                held_extended <= 1'b0;
                held_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
`timescale 1ns/1ps

module tb_ps2_scancode_decoder;

    localparam int unsigned Timeout = 100;

    logic       CLOCK_50;
    logic       reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       key_event;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_released;
    logic [7:0] held_code;
    logic       held_extended;
    logic       held_valid;
    logic       seq_error;

    ps2_scancode_decoder #(
        .TIMEOUT_CYCLES(Timeout),
        .CNT_WIDTH     (8)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .received_data   (received_data),
        .received_data_en(received_data_en),
        .key_event       (key_event),
        .key_code        (key_code),
        .key_extended    (key_extended),
        .key_released    (key_released),
        .held_code       (held_code),
        .held_extended   (held_extended),
        .held_valid      (held_valid),
        .seq_error       (seq_error)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Captured DUT events and model expectations, packed {code, ext, rel}.
    logic [9:0] got_q [$];
    logic [9:0] exp_q [$];
    int         err_cnt  = 0;
    int         both_cnt = 0;

    // Reference model of the held key.
    logic       m_hv = 1'b0;
    logic [7:0] m_hc = 8'h00;
    logic       m_he = 1'b0;

    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (key_event) got_q.push_back({key_code, key_extended, key_released});
            if (seq_error) err_cnt++;
            if (key_event && seq_error) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Present one byte for exactly one rising edge; returns at the following
    // negedge, where a latency-1 result is already visible.
    task automatic send(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
    endtask

    task automatic model_press(input logic [7:0] c, input logic e);
`ifdef REPEAT_FILTER_EN
        if (m_hv && (m_hc == c) && (m_he == e)) return;
`endif
        exp_q.push_back({c, e, 1'b0});
        m_hv = 1'b1;
        m_hc = c;
        m_he = e;
    endtask

    task automatic model_release(input logic [7:0] c, input logic e);
        exp_q.push_back({c, e, 1'b1});
        if (m_hv && (m_hc == c) && (m_he == e)) begin
            m_hv = 1'b0;
            m_hc = 8'h00;
            m_he = 1'b0;
        end
    endtask

    // kind 0 = press, 1 = release, other = Pause key.
    task automatic do_action(input int kind, input logic [7:0] code, input logic ext,
                             input int max_gap);
        logic [7:0] b [$];
        case (kind)
            0: begin
                if (ext) b.push_back(8'hE0);
                b.push_back(code);
                model_press(code, ext);
            end
            1: begin
                if (ext) b.push_back(8'hE0);
                b.push_back(8'hF0);
                b.push_back(code);
                model_release(code, ext);
            end
            default: begin
                b = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
                model_press(8'hE1, 1'b1);
            end
        endcase
        foreach (b[i]) begin
            send(b[i]);
            if ((max_gap > 0) && (i < b.size() - 1)) tick(int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic compare_events(input string tag);
        tick(3);
        check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; (i < got_q.size()) && (i < exp_q.size()); i++) begin
            check({tag, " event"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_held(input string tag);
        check(tag, {23'd0, held_valid, held_extended, held_code}, {23'd0, m_hv, m_he, m_hc});
    endtask

    function automatic logic [31:0] all_outputs();
        return {10'd0, key_event, key_code, key_extended, key_released,
                held_code, held_extended, held_valid, seq_error};
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] codes [6];
        int         e0;
        codes = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h74};

        reset            = 1'b1;
        received_data    = 8'h00;
        received_data_en = 1'b0;
        tick(3);
        check("reset outputs", all_outputs(), 32'd0);
        reset = 1'b0;
        tick(2);

        // Plain make then break, with exact latency and pulse width.
        send(8'h1C);
        model_press(8'h1C, 1'b0);
        check("make pulse", {31'd0, key_event}, 32'd1);
        check("make fields", {22'd0, key_code, key_extended, key_released}, {22'd0, 8'h1C, 2'b00});
        check_held("make held");
        tick(1);
        check("make pulse width", {31'd0, key_event}, 32'd0);
        send(8'hF0);
        check("no event on F0", {31'd0, key_event}, 32'd0);
        send(8'h1C);
        model_release(8'h1C, 1'b0);
        check("break pulse", {31'd0, key_event}, 32'd1);
        check("break fields", {22'd0, key_code, key_extended, key_released},
              {22'd0, 8'h1C, 2'b01});
        check_held("break held");
        compare_events("plain");

        // Extended make/break and fake-shift bytes.
        do_action(0, 8'h75, 1'b1, 0);
        check_held("ext make held");
        do_action(1, 8'h75, 1'b1, 0);
        send(8'hE0); send(8'h12);
        send(8'hE0); send(8'hF0); send(8'h12);
        check_held("ext break held");
        compare_events("extended");

        // Pause: one event after the eighth byte only.
        e0 = err_cnt;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0);
        check("pause early", {31'd0, key_event}, 32'd0);
        send(8'h77);
        model_press(8'hE1, 1'b1);
        check("pause pulse", {31'd0, key_event}, 32'd1);
        compare_events("pause");
        check("pause no error", 32'(err_cnt - e0), 32'd0);

        // Timeout after a lone F0, then normal decoding resumes.
        e0 = err_cnt;
        send(8'hF0);
        tick(Timeout - 1);
        check("timeout not yet", {31'd0, seq_error}, 32'd0);
        tick(1);
        check("timeout pulse", {31'd0, seq_error}, 32'd1);
        tick(1);
        check("timeout pulse width", {31'd0, seq_error}, 32'd0);
        send(8'h1C);
        model_press(8'h1C, 1'b0);
        compare_events("after timeout");
        check("timeout error count", 32'(err_cnt - e0), 32'd1);

        // A strobe on the last counting cycle wins over the timeout.
        e0 = err_cnt;
        send(8'hF0);
        tick(Timeout - 1);
        send(8'h1C);
        model_release(8'h1C, 1'b0);
        compare_events("strobe at limit");
        check("strobe at limit error", 32'(err_cnt - e0), 32'd0);

        // Malformed break: F0 F0 flags an error and produces nothing.
        e0 = err_cnt;
        send(8'hF0); send(8'hF0);
        compare_events("double F0");
        check("double F0 error", 32'(err_cnt - e0), 32'd1);

        // Typematic repeats and status bytes.
        do_action(0, 8'h1C, 1'b0, 0);
        do_action(0, 8'h1C, 1'b0, 0);
        do_action(0, 8'h1C, 1'b0, 0);
        send(8'hAA); send(8'hFA);
        compare_events("repeat");
        check_held("repeat held");

        // Reset in the middle of an extended sequence.
        send(8'hE0);
        #3 reset = 1'b1;
        #2 check("mid-seq reset outputs", all_outputs(), 32'd0);
        m_hv = 1'b0; m_hc = 8'h00; m_he = 1'b0;
        got_q.delete();
        exp_q.delete();
        @(negedge CLOCK_50);
        reset = 1'b0;
        send(8'h75);
        model_press(8'h75, 1'b0);
        check("post-reset fields", {22'd0, key_code, key_extended, key_released},
              {22'd0, 8'h75, 2'b00});
        compare_events("post reset");

        // Random press/release/pause traffic with short inter-byte gaps.
        e0 = err_cnt;
        for (int n = 0; n < 200; n++) begin
            int r;
            r = int'($urandom_range(19, 0));
            do_action((r < 9) ? 0 : ((r < 18) ? 1 : 2), codes[$urandom_range(5, 0)],
                      1'($urandom_range(1, 0)), 3);
            tick(int'($urandom_range(5, 0)));
        end
        compare_events("random");
        check_held("random held");
        check("random no error", 32'(err_cnt - e0), 32'd0);
        check("event and error exclusive", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
